// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parameterised up/down counter with load, terminal count and wrap/saturate pulse
module param_updown_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_next;

  assign at_top    = (q == MAX_COUNT);
  assign at_bottom = (q == '0);

  // Terminal count: the step about to be taken would leave the 0..MAX_COUNT range.
  assign tc = en & ((up & at_top) | (~up & at_bottom));

  // Out-of-range load values are pinned to the top of the range so q never exceeds MAX_COUNT.
  assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  // Next-count selection: load beats enable; at a range end either wrap or hold.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_clamped;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          q_next = SATURATE ? MAX_COUNT : '0;
        end else begin
          q_next = q + ONE;
        end
      end else begin
        if (at_bottom) begin
          q_next = SATURATE ? '0 : MAX_COUNT;
        end else begin
          q_next = q - ONE;
        end
      end
    end
  end

  // Count register and event pulse; a load or reset on a terminal edge suppresses the pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= tc & ~load;
    end
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_COUNT, default 2**WIDTH-1, terminal value of the count range 0..MAX_COUNT (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0, where 0 = wrap at range ends and 1 = hold at range ends.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  count enable; one step per cycle while high.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH  value captured when load is high.
REQ-010 q  output  WIDTH  registered count value.
REQ-011 tc  output  1  terminal-count flag, combinational from q, up, en.
REQ-012 ovf  output  1  registered one-cycle wrap/saturate event pulse.

Function
REQ-013 Per-edge priority SHALL be: reset, then load, then en; with none active, q holds.
REQ-014 On load, q SHALL take load_val next cycle; load_val > MAX_COUNT SHALL clamp to MAX_COUNT.
REQ-015 With en=1, up=1, q<MAX_COUNT, q SHALL become q+1 next cycle.
REQ-016 With en=1, up=0, q>0, q SHALL become q-1 next cycle.
REQ-017 With en=1, up=1, q==MAX_COUNT: q SHALL become 0 (SATURATE=0) or hold MAX_COUNT (SATURATE=1).
REQ-018 With en=1, up=0, q==0: q SHALL become MAX_COUNT (SATURATE=0) or hold 0 (SATURATE=1).
REQ-019 q SHALL never exceed MAX_COUNT, including when MAX_COUNT < 2**WIDTH-1.
REQ-020 tc SHALL be high exactly when en=1 and ((up=1 and q==MAX_COUNT) or (up=0 and q==0)), same cycle, zero latency.
REQ-021 ovf SHALL be high for exactly one cycle, the cycle after an edge where tc=1 and load=0 and reset_n=1; otherwise low.
REQ-022 A load coincident with tc=1 SHALL take priority and SHALL NOT produce an ovf pulse.
REQ-023 A change of up while en=1 SHALL take effect on the same edge, with no idle or extra cycle.
REQ-024 With SATURATE=1, ovf SHALL pulse on every enabled cycle that attempts to step past a range end (repeated pulses while held).
REQ-025 Counting SHALL be synchronous: all q bits update on the same edge, no ripple.

Reset
REQ-026 When reset_n=0 at a rising edge, q SHALL be 0 and ovf SHALL be 0 next cycle, regardless of en, load, up.
REQ-027 Reset asserted mid-count SHALL abort counting at that edge; no ovf SHALL be generated from the aborted step.
REQ-028 First edge with reset_n=1 SHALL process en/load normally (no dead cycle).
REQ-029 reset_n changes between edges SHALL have no effect until the next rising edge.

Verification (WIDTH=4, MAX_COUNT=9 unless stated)
REQ-030 Reset then en=1, up=1 for 12 cycles -> q = 1..9, 0, 1, 2; tc high while q=9; ovf pulse the cycle q becomes 0.
REQ-031 Reset then en=1, up=0 for 3 cycles -> q = 9, 8, 7; tc high while q=0 in first cycle; ovf pulse in second cycle.
REQ-032 SATURATE=1, load 8, en=1, up=1 for 4 cycles -> q = 9, 9, 9, 9; ovf high in cycles 3, 4 and one after.
REQ-033 load=1, load_val=15 -> q=9; load=1 with en=1, up=1, q=9 -> q=load_val, no ovf.
REQ-034 Count up to q=5, assert reset_n=0 with en=1, load=1 -> q=0, ovf=0 next cycle; release -> q=1 after first edge.
REQ-035 WIDTH=8, MAX_COUNT default (255), up toggled every cycle from q=0 -> q = 255 (wrap, ovf), 0... pattern matches reference model every cycle.
